priority_dec_pipe: RTL and testbench

PRIORITY_DEC_PIPE -- requirements
Module: priority_dec_pipe

---
 rtl/priority_dec_pkg.sv | 10 +
 rtl/bin2pos.sv | 22 ++
 rtl/priority_dec_pipe.sv | 126 ++++++++++++
 tb/tb_priority_dec_pipe.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/priority_dec_pkg.sv
// Shared types for the priority decoder pipeline: occupancy state of the skid buffer.
package priority_dec_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/bin2pos.sv
// Combinational binary-to-one-hot decoder; flags indices that have no output bit.
module bin2pos #(
    parameter int WIDTH   = 32,
    parameter int WIDTH_W = $clog2(WIDTH)
) (
    input  logic [WIDTH_W-1:0] bin,
    output logic [WIDTH-1:0]   pos,
    output logic               err_range
);

    always_comb begin
        pos       = '0;
        err_range = 1'b1;
        for (int k = 0; k < WIDTH; k++) begin
            if (bin == WIDTH_W'(k)) begin
                pos[k]    = 1'b1;
                err_range = 1'b0;
            end
        end
    end

endmodule

// File: rtl/priority_dec_pipe.sv
// One-cycle binary-to-one-hot decode stage with a two-entry skid buffer.
//
// state | meaning
// EMPTY | no words held, outputs zero
// ONE   | main register holds the output word
// TWO   | main and skid registers full, input stalled
module priority_dec_pipe
    import priority_dec_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int WIDTH_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               id_valid,
    input  logic [WIDTH_W-1:0] id_bin,
    output logic               id_ready,
    output logic               od_valid,
    input  logic               od_ready,
    output logic [WIDTH-1:0]   od_pos,
    output logic               od_err,
    output logic               err_sticky,
    input  logic               err_clr
);

    skid_state_t      state, state_nxt;
    logic [WIDTH-1:0] dec_pos;
    logic             dec_err;
    logic [WIDTH-1:0] main_pos, main_pos_nxt, skid_pos, skid_pos_nxt;
    logic             main_err, main_err_nxt, skid_err, skid_err_nxt;
    logic             id_ready_q, od_valid_q;
    logic             in_xfer, out_xfer;

    bin2pos #(
        .WIDTH   (WIDTH),
        .WIDTH_W (WIDTH_W)
    ) u_bin2pos (
        .bin       (id_bin),
        .pos       (dec_pos),
        .err_range (dec_err)
    );

    assign in_xfer  = id_valid & id_ready_q;
    assign out_xfer = od_valid_q & od_ready;

    always_comb begin
        state_nxt    = state;
        main_pos_nxt = main_pos;
        main_err_nxt = main_err;
        skid_pos_nxt = skid_pos;
        skid_err_nxt = skid_err;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    state_nxt    = ONE;
                    main_pos_nxt = dec_pos;
                    main_err_nxt = dec_err;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    main_pos_nxt = dec_pos;
                    main_err_nxt = dec_err;
                end else if (in_xfer) begin
                    state_nxt    = TWO;
                    skid_pos_nxt = dec_pos;
                    skid_err_nxt = dec_err;
                end else if (out_xfer) begin
                    // Clear the main word so the outputs read zero while empty.
                    state_nxt    = EMPTY;
                    main_pos_nxt = '0;
                    main_err_nxt = 1'b0;
                end
            end
            TWO: begin
                if (out_xfer) begin
                    state_nxt    = ONE;
                    main_pos_nxt = skid_pos;
                    main_err_nxt = skid_err;
                end
            end
            default: begin
                state_nxt    = EMPTY;
                main_pos_nxt = '0;
                main_err_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= EMPTY;
            main_pos   <= '0;
            main_err   <= 1'b0;
            skid_pos   <= '0;
            skid_err   <= 1'b0;
            id_ready_q <= 1'b1;
            od_valid_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            main_pos   <= main_pos_nxt;
            main_err   <= main_err_nxt;
            skid_pos   <= skid_pos_nxt;
            skid_err   <= skid_err_nxt;
            id_ready_q <= (state_nxt != TWO);
            od_valid_q <= (state_nxt != EMPTY);
        end
    end

    // A new out-of-range index takes priority over a clear on the same edge.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            err_sticky <= 1'b0;
        end else if (in_xfer && dec_err) begin
            err_sticky <= 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end
    end

    assign id_ready = id_ready_q;
    assign od_valid = od_valid_q;
    assign od_pos   = main_pos;
    assign od_err   = main_err;

endmodule

// File: tb/tb_priority_dec_pipe.sv
// Directed and randomised checks of priority_dec_pipe at WIDTH=8 and WIDTH=5.
module tb_priority_dec_pipe;

    logic       clk = 1'b0;
    logic       nrst_a, nrst_b;

    logic       a_id_valid, a_id_ready, a_od_valid, a_od_ready, a_od_err, a_err_sticky, a_err_clr;
    logic [2:0] a_id_bin;
    logic [7:0] a_od_pos;

    logic       b_id_valid, b_id_ready, b_od_valid, b_od_ready, b_od_err, b_err_sticky, b_err_clr;
    logic [2:0] b_id_bin;
    logic [4:0] b_od_pos;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    priority_dec_pipe #(.WIDTH(8), .WIDTH_W(3)) u_dut_a (
        .clk        (clk),
        .nrst       (nrst_a),
        .id_valid   (a_id_valid),
        .id_bin     (a_id_bin),
        .id_ready   (a_id_ready),
        .od_valid   (a_od_valid),
        .od_ready   (a_od_ready),
        .od_pos     (a_od_pos),
        .od_err     (a_od_err),
        .err_sticky (a_err_sticky),
        .err_clr    (a_err_clr)
    );

    priority_dec_pipe #(.WIDTH(5), .WIDTH_W(3)) u_dut_b (
        .clk        (clk),
        .nrst       (nrst_b),
        .id_valid   (b_id_valid),
        .id_bin     (b_id_bin),
        .id_ready   (b_id_ready),
        .od_valid   (b_od_valid),
        .od_ready   (b_od_ready),
        .od_pos     (b_od_pos),
        .od_err     (b_od_err),
        .err_sticky (b_err_sticky),
        .err_clr    (b_err_clr)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] prev_pos;
        logic [7:0] exp_word;
        logic       prev_stall;
        logic       in_x, out_x;
        int         stall_bad, flow_bad;

        nrst_a = 1'b0; nrst_b = 1'b0;
        a_id_valid = 1'b0; a_id_bin = '0; a_od_ready = 1'b0; a_err_clr = 1'b0;
        b_id_valid = 1'b0; b_id_bin = '0; b_od_ready = 1'b0; b_err_clr = 1'b0;

        repeat (2) @(negedge clk);
        check_val("rst_od_valid", 32'(a_od_valid), 32'd0);
        check_val("rst_id_ready", 32'(a_id_ready), 32'd1);
        check_val("rst_od_pos", 32'(a_od_pos), 32'd0);
        check_val("rst_err_sticky", 32'(b_err_sticky), 32'd0);

        // First word right after reset release, index 3.
        nrst_a = 1'b1; nrst_b = 1'b1;
        a_id_valid = 1'b1; a_id_bin = 3'd3; a_od_ready = 1'b1;
        @(negedge clk);
        check_val("w8_valid", 32'(a_od_valid), 32'd1);
        check_val("w8_pos3", 32'(a_od_pos), 32'h08);
        check_val("w8_err", 32'(a_od_err), 32'd0);
        a_id_valid = 1'b0;
        @(negedge clk);
        check_val("w8_drain_valid", 32'(a_od_valid), 32'd0);
        check_val("w8_drain_pos", 32'(a_od_pos), 32'd0);

        // Back-to-back 0,1,2 with downstream stalled.
        a_od_ready = 1'b0; a_id_valid = 1'b1; a_id_bin = 3'd0;
        @(negedge clk);
        check_val("bp_ready_one", 32'(a_id_ready), 32'd1);
        a_id_bin = 3'd1;
        @(negedge clk);
        check_val("bp_ready_two", 32'(a_id_ready), 32'd0);
        check_val("bp_pos0", 32'(a_od_pos), 32'h01);
        a_id_bin = 3'd2;
        @(negedge clk);
        check_val("bp_hold_pos", 32'(a_od_pos), 32'h01);
        check_val("bp_hold_ready", 32'(a_id_ready), 32'd0);
        a_od_ready = 1'b1;
        @(negedge clk);
        check_val("bp_pos1", 32'(a_od_pos), 32'h02);
        check_val("bp_ready_back", 32'(a_id_ready), 32'd1);
        @(negedge clk);
        check_val("bp_pos2", 32'(a_od_pos), 32'h04);
        a_id_valid = 1'b0;
        @(negedge clk);
        check_val("bp_empty", 32'(a_od_valid), 32'd0);

        // Continuous stream 0..7.
        for (int i = 0; i <= 8; i++) begin
            if (i > 0) begin
                check_val("str_pos", 32'(a_od_pos), 32'(8'(1) << (i - 1)));
                check_val("str_valid", 32'(a_od_valid), 32'd1);
                check_val("str_ready", 32'(a_id_ready), 32'd1);
            end
            if (i < 8) begin
                a_id_valid = 1'b1; a_id_bin = 3'(i);
            end else begin
                a_id_valid = 1'b0;
            end
            @(negedge clk);
        end
        check_val("str_done", 32'(a_od_valid), 32'd0);

        // Out-of-range handling at WIDTH=5.
        b_id_valid = 1'b1; b_id_bin = 3'd6; b_od_ready = 1'b1;
        @(negedge clk);
        check_val("w5_oor_valid", 32'(b_od_valid), 32'd1);
        check_val("w5_oor_pos", 32'(b_od_pos), 32'd0);
        check_val("w5_oor_err", 32'(b_od_err), 32'd1);
        check_val("w5_sticky_set", 32'(b_err_sticky), 32'd1);
        b_id_bin = 3'd4;
        @(negedge clk);
        check_val("w5_top_pos", 32'(b_od_pos), 32'h10);
        check_val("w5_top_err", 32'(b_od_err), 32'd0);
        b_id_valid = 1'b0;
        @(negedge clk);
        check_val("w5_idle_valid", 32'(b_od_valid), 32'd0);
        check_val("w5_idle_err", 32'(b_od_err), 32'd0);
        check_val("w5_sticky_hold", 32'(b_err_sticky), 32'd1);
        b_err_clr = 1'b1;
        @(negedge clk);
        check_val("w5_sticky_clr", 32'(b_err_sticky), 32'd0);
        b_id_valid = 1'b1; b_id_bin = 3'd5;
        @(negedge clk);
        check_val("w5_set_wins", 32'(b_err_sticky), 32'd1);
        check_val("w5_oor5_err", 32'(b_od_err), 32'd1);
        b_id_valid = 1'b0; b_err_clr = 1'b0;
        @(negedge clk);
        check_val("w5_end_valid", 32'(b_od_valid), 32'd0);

        // Reset while both registers are full.
        a_od_ready = 1'b0; a_id_valid = 1'b1; a_id_bin = 3'd5;
        @(negedge clk);
        a_id_bin = 3'd6;
        @(negedge clk);
        check_val("rt_two_ready", 32'(a_id_ready), 32'd0);
        check_val("rt_two_pos", 32'(a_od_pos), 32'h20);
        a_id_valid = 1'b0;
        #3 nrst_a = 1'b0;
        #1;
        check_val("rt_async_valid", 32'(a_od_valid), 32'd0);
        check_val("rt_async_ready", 32'(a_id_ready), 32'd1);
        check_val("rt_async_pos", 32'(a_od_pos), 32'd0);
        check_val("rt_async_err", 32'(a_od_err), 32'd0);
        @(negedge clk);
        nrst_a = 1'b1; a_od_ready = 1'b1;
        @(negedge clk);
        check_val("rt_no_stale1", 32'(a_od_valid), 32'd0);
        @(negedge clk);
        check_val("rt_no_stale2", 32'(a_od_valid), 32'd0);
        check_val("rt_no_stale_pos", 32'(a_od_pos), 32'd0);

        // Random handshakes against a queue model.
        stall_bad = 0; flow_bad = 0; prev_stall = 1'b0; prev_pos = '0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if (prev_stall && a_od_pos !== prev_pos) stall_bad++;
            if (a_od_valid !== (q.size() > 0)) flow_bad++;
            if (a_id_ready !== (q.size() < 2)) flow_bad++;
            if (!a_od_valid && a_od_pos !== 8'd0) flow_bad++;
            a_id_valid = 1'($urandom_range(0, 1));
            a_id_bin   = 3'($urandom_range(0, 7));
            a_od_ready = 1'($urandom_range(0, 1));
            in_x  = a_id_valid && a_id_ready;
            out_x = a_od_valid && a_od_ready;
            if (out_x) begin
                if (q.size() == 0) begin
                    flow_bad++;
                end else begin
                    exp_word = q.pop_front();
                    check_val("rand_word", 32'(a_od_pos), 32'(exp_word));
                end
            end
            if (in_x) q.push_back(8'(1) << a_id_bin);
            prev_stall = a_od_valid && !a_od_ready;
            prev_pos   = a_od_pos;
        end
        check_val("rand_stall", 32'(stall_bad), 32'd0);
        check_val("rand_flow", 32'(flow_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
